// File: rtl/alu_operand_sequencer.sv
// Step-by-step operand loader for a combinational ALU: captures A, B and the opcode on
// successive enter presses, waits SETTLE cycles, then registers the result and flags.
module alu_operand_sequencer #(
    parameter int N      = 3,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         enter,
    input  logic [N-1:0] data_in,
    input  logic [3:0]   sel_in,
    input  logic         flag_in,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel,
    output logic         alu_flagin,
    input  logic [N-1:0] alu_res,
    input  logic         alu_neg,
    input  logic         alu_zero,
    input  logic         alu_cout,
    input  logic         alu_ovf,
    output logic [N-1:0] res_q,
    output logic [3:0]   flags_q,
    output logic         res_valid,
    output logic         done,
    output logic [1:0]   state_o
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        EXEC    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]     sel_q, sel_d;
    logic           flagin_q, flagin_d;
    logic [N-1:0]   res_d;
    logic [3:0]     flags_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           enter_q, enter_d;
    logic           step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            flagin_q <= 1'b0;
            res_q    <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            enter_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            flagin_q <= flagin_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            enter_q  <= enter_d;
        end
    end

    // enter_q idles high after reset so a button held through reset never counts as a press
    assign step = enter & ~enter_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        flagin_d = flagin_q;
        res_d    = res_q;
        flags_d  = flags_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        enter_d  = enter;

        if (clr) begin
            state_d  = LOAD_A;
            a_d      = '0;
            b_d      = '0;
            sel_d    = '0;
            flagin_d = 1'b0;
            res_d    = '0;
            flags_d  = '0;
            valid_d  = 1'b0;
            cnt_d    = '0;
            enter_d  = 1'b1;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (step) begin
                        a_d     = data_in;
                        valid_d = 1'b0;
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (step) begin
                        b_d     = data_in;
                        state_d = LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (step) begin
                        sel_d    = sel_in;
                        flagin_d = flag_in;
                        cnt_d    = CW'(SETTLE - 1);
                        state_d  = EXEC;
                    end
                end
                EXEC: begin
                    // presses during EXEC are dropped; operands stay frozen for the ALU
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        res_d   = alu_res;
                        flags_d = {alu_neg, alu_zero, alu_cout, alu_ovf};
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = LOAD_A;
                    end
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = sel_q;
    assign alu_flagin = flagin_q;
    assign res_valid  = valid_q;
    assign done       = done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: two instances (SETTLE=1 and SETTLE=3) driven by the same
// switches, each with a stand-in ALU, checked every cycle against an operation-level model.
module tb_alu_operand_sequencer;

    localparam int N  = 3;
    localparam int PW = 3 * N + 13;

    logic         clk, rst_n, clr, enter, flag_in;
    logic [N-1:0] data_in;
    logic [3:0]   sel_in;

    logic [N-1:0] a1, b1, res1, rq1, a3, b3, res3, rq3;
    logic [3:0]   sel1, fq1, sel3, fq3;
    logic         fi1, neg1, zero1, cout1, ovf1, v1, d1;
    logic         fi3, neg3, zero3, cout3, ovf3, v3, d3;
    logic [1:0]   st1, st3;

    int vectors = 0;
    int miscompares = 0;
    int execn, donen;

    // Stand-in ALU: 0 ADD (overflow flag = unsigned carry), 1 SUB, 2 ADC, 4 AND, 5 OR,
    // 6 XOR, 7 NOT A, others pass A with carry = flagin. Returns {res, neg, zero, cout, ovf}.
    function automatic logic [N+3:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [3:0] s, input logic fi);
        logic [N:0]   t;
        logic [N-1:0] r;
        logic         c, v;
        t = '0; c = 1'b0; v = 1'b0; r = a;
        case (s)
            4'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[N-1:0]; c = t[N]; v = c; end
            4'd1: begin
                t = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
                r = t[N-1:0]; c = t[N];
                v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            4'd2: begin t = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, fi}; r = t[N-1:0]; c = t[N]; end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = ~a;
            default: begin r = a; c = fi; end
        endcase
        return {r, r[N-1], (r == '0), c, v};
    endfunction

    assign {res1, neg1, zero1, cout1, ovf1} = alu_fn(a1, b1, sel1, fi1);
    assign {res3, neg3, zero3, cout3, ovf3} = alu_fn(a3, b3, sel3, fi3);

    alu_operand_sequencer #(.N(N), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .enter(enter), .data_in(data_in),
        .sel_in(sel_in), .flag_in(flag_in), .alu_a(a1), .alu_b(b1), .alu_sel(sel1),
        .alu_flagin(fi1), .alu_res(res1), .alu_neg(neg1), .alu_zero(zero1),
        .alu_cout(cout1), .alu_ovf(ovf1), .res_q(rq1), .flags_q(fq1),
        .res_valid(v1), .done(d1), .state_o(st1));

    alu_operand_sequencer #(.N(N), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .enter(enter), .data_in(data_in),
        .sel_in(sel_in), .flag_in(flag_in), .alu_a(a3), .alu_b(b3), .alu_sel(sel3),
        .alu_flagin(fi3), .alu_res(res3), .alu_neg(neg3), .alu_zero(zero3),
        .alu_cout(cout3), .alu_ovf(ovf3), .res_q(rq3), .flags_q(fq3),
        .res_valid(v3), .done(d3), .state_o(st3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operation-level model: how many operands are held, whether an operation is running
    // and how many EXEC cycles it still needs.
    typedef struct {
        int           loaded;
        logic         busy;
        int           left;
        logic [N-1:0] a, b, res;
        logic [3:0]   sel, fl;
        logic         fi, valid, done, prev;
    } mdl_t;

    mdl_t m1, m3;

    function automatic mdl_t mreset();
        mdl_t r;
        r.loaded = 0; r.busy = 1'b0; r.left = 0;
        r.a = '0; r.b = '0; r.res = '0; r.sel = '0; r.fl = '0;
        r.fi = 1'b0; r.valid = 1'b0; r.done = 1'b0; r.prev = 1'b1;
        return r;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int settle, input logic rn,
                                   input logic cl, input logic en, input logic [N-1:0] d,
                                   input logic [3:0] s, input logic f);
        mdl_t n;
        logic [N+3:0] o;
        if (!rn || cl) return mreset();
        n = m;
        n.done = 1'b0;
        n.prev = en;
        if (m.busy) begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                o = alu_fn(m.a, m.b, m.sel, m.fi);
                n.res = o[N+3:4]; n.fl = o[3:0];
                n.valid = 1'b1; n.done = 1'b1; n.busy = 1'b0;
            end
        end else if (en && !m.prev) begin
            case (m.loaded)
                0: begin n.a = d; n.valid = 1'b0; n.loaded = 1; end
                1: begin n.b = d; n.loaded = 2; end
                default: begin
                    n.sel = s; n.fi = f; n.busy = 1'b1; n.left = settle; n.loaded = 0;
                end
            endcase
        end
        return n;
    endfunction

    function automatic logic [PW-1:0] mpack(input mdl_t m);
        return {(m.busy ? 2'd3 : 2'(m.loaded)), m.a, m.b, m.sel, m.fi, m.res, m.fl,
                m.valid, m.done};
    endfunction

    always @(posedge clk) begin
        m1 <= mstep(m1, 1, rst_n, clr, enter, data_in, sel_in, flag_in);
        m3 <= mstep(m3, 3, rst_n, clr, enter, data_in, sel_in, flag_in);
    end

    function automatic logic [PW-1:0] pack1();
        return {st1, a1, b1, sel1, fi1, rq1, fq1, v1, d1};
    endfunction

    function automatic logic [PW-1:0] pack3();
        return {st3, a3, b3, sel3, fi3, rq3, fq3, v3, d3};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare both instances with the model.
    task automatic cyc();
        @(negedge clk);
        chk("model_settle1", 32'(pack1()), 32'(mpack(m1)));
        chk("model_settle3", 32'(pack3()), 32'(mpack(m3)));
    endtask

    task automatic press(input logic [N-1:0] d, input logic [3:0] s, input logic f);
        enter = 1'b0;
        cyc();
        data_in = d; sel_in = s; flag_in = f; enter = 1'b1;
        cyc();
    endtask

    typedef struct {
        logic         en;
        logic [N-1:0] d;
        logic [3:0]   s;
        logic [1:0]   st;
        logic [N-1:0] a, b;
        logic [3:0]   sl;
        logic [N-1:0] r;
        logic [3:0]   fl;
        logic         v, dn;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // Expected SETTLE=1 outputs after each edge: 3 + 5 with ADD, then a new A=1.
        tbl[0] = '{1'b1, 3'd3, 4'd0, 2'd1, 3'd3, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 3'd0, 4'd0, 2'd1, 3'd3, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 3'd5, 4'd0, 2'd2, 3'd3, 3'd5, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 3'd0, 4'd0, 2'd2, 3'd3, 3'd5, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 3'd0, 4'd0, 2'd3, 3'd3, 3'd5, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 3'd0, 4'd0, 2'd0, 3'd3, 3'd5, 4'd0, 3'd0, 4'd7, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 3'd0, 4'd0, 2'd0, 3'd3, 3'd5, 4'd0, 3'd0, 4'd7, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 3'd1, 4'd0, 2'd1, 3'd1, 3'd5, 4'd0, 3'd0, 4'd7, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 3'd2, 4'd0, 2'd1, 3'd1, 3'd5, 4'd0, 3'd0, 4'd7, 1'b0, 1'b0};

        rst_n = 1'b1; clr = 1'b0; enter = 1'b1; data_in = '0; sel_in = '0; flag_in = 1'b0;
        #1 rst_n = 1'b0;
        cyc();
        cyc();
        chk("reset_s1", 32'(pack1()), 32'd0);
        chk("reset_s3", 32'(pack3()), 32'd0);

        // Release reset with enter still held: no step until it is released and pressed.
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("held_enter_no_step", 32'(st1), 32'd0);
        enter = 1'b0;
        cyc();

        for (int i = 0; i < 9; i++) begin
            enter = tbl[i].en; data_in = tbl[i].d; sel_in = tbl[i].s; flag_in = 1'b0;
            cyc();
            chk($sformatf("table_row%0d", i), 32'(pack1()),
                32'({tbl[i].st, tbl[i].a, tbl[i].b, tbl[i].sl, 1'b0, tbl[i].r, tbl[i].fl,
                     tbl[i].v, tbl[i].dn}));
        end

        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_s1", 32'(pack1()), 32'd0);
        chk("clr_s3", 32'(pack3()), 32'd0);

        // clr in LOAD_OP, coinciding with a genuine step.
        press(3'd6, 4'd0, 1'b0);
        press(3'd3, 4'd0, 1'b0);
        chk("in_load_op", 32'(st3), 32'd2);
        enter = 1'b0;
        cyc();
        sel_in = 4'd4; enter = 1'b1; clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_load_op_s3", 32'(pack3()), 32'd0);
        chk("clr_load_op_s1", 32'(pack1()), 32'd0);

        // SETTLE=3 AND of 6 and 3 with an extra press landing in EXEC.
        press(3'd6, 4'd0, 1'b0);
        press(3'd3, 4'd0, 1'b0);
        enter = 1'b0;
        cyc();
        data_in = 3'd0; sel_in = 4'd4; flag_in = 1'b0; enter = 1'b1;
        execn = 0; donen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (st3 == 2'd3) execn++;
            if (d3) donen++;
            enter = (i == 1);
        end
        chk("exec_cycles_s3", 32'(execn), 32'd3);
        chk("done_pulses_s3", 32'(donen), 32'd1);
        chk("and_res_s3", 32'(rq3), 32'd2);
        chk("and_flags_s3", 32'(fq3), 32'd0);
        chk("and_valid_s3", 32'(v3), 32'd1);
        chk("after_exec_state_s3", 32'(st3), 32'd0);
        chk("extra_press_ignored_a", 32'(a3), 32'd6);

        // Asynchronous reset in the middle of EXEC.
        press(3'd1, 4'd0, 1'b0);
        press(3'd2, 4'd0, 1'b0);
        enter = 1'b0;
        cyc();
        sel_in = 4'd1; enter = 1'b1;
        cyc();
        chk("mid_exec_state", 32'(st3), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_exec_s3", 32'(pack3()), 32'd0);
        chk("rst_mid_exec_s1", 32'(pack1()), 32'd0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("no_done_after_abort", 32'({st3, d3}), 32'd0);
        end

        // Randomized switches, presses, clears and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            #1;
            rst_n   = ($urandom_range(0, 299) != 0);
            clr     = ($urandom_range(0, 63) == 0);
            enter   = 1'($urandom_range(0, 1));
            data_in = N'($urandom);
            sel_in  = 4'($urandom);
            flag_in = 1'($urandom);
        end
        rst_n = 1'b1; clr = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream/downstream wrapper stage for the combinational ALU: captures operand A, operand B and the operation code from board switches on successive presses of an "enter" input.
- Drives the registered operands onto the ALU, waits a programmable settle time, then registers the ALU result and the four flags for display.
- Sits between the switch/button front end and the ALU/display back end, and turns the combinational ALU into a clocked, step-by-step datapath.

Parameters:
N, 3, operand/result width; must match the ALU width
SETTLE, 1, number of EXEC cycles (>=1) between applying operands and capturing the result

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear; same effect as reset, applied on the clock edge
enter  input  1  level input, already synchronised/debounced; each rising edge is one step
data_in  input  N  operand value from switches
sel_in  input  4  operation code from switches
flag_in  input  1  ALU flagin value from switch
alu_a  output  N  registered operand A to ALU
alu_b  output  N  registered operand B to ALU
alu_sel  output  4  registered select to ALU
alu_flagin  output  1  registered flagin to ALU
alu_res  input  N  ALU result
alu_neg  input  1  ALU negative flag
alu_zero  input  1  ALU zero flag
alu_cout  input  1  ALU carry-out flag
alu_ovf  input  1  ALU overflow flag
res_q  output  N  captured result
flags_q  output  4  captured flags {neg, zero, cout, ovf}
res_valid  output  1  res_q/flags_q hold a result for the current operand set
done  output  1  one-cycle pulse when a result is captured
state_o  output  2  FSM state for LEDs: 0=LOAD_A, 1=LOAD_B, 2=LOAD_OP, 3=EXEC

Behaviour:
Reset and clear:
- On rst_n low (async) or clr high (sync): state=LOAD_A; alu_a=alu_b=0; alu_sel=0; alu_flagin=0; res_q=0; flags_q=0; res_valid=0; done=0; settle counter=0; enter_q=1.
- clr has priority over every other event in that cycle.

Edge detection:
- enter_q <= enter every cycle; step = enter & ~enter_q.
- enter_q resets to 1, so a button held through reset produces no step until it is released and pressed again.

FSM:
- LOAD_A: on step, alu_a<=data_in, res_valid<=0, go to LOAD_B.
- LOAD_B: on step, alu_b<=data_in, go to LOAD_OP.
- LOAD_OP: on step, alu_sel<=sel_in, alu_flagin<=flag_in, counter<=SETTLE-1, go to EXEC.
- EXEC: if counter!=0, decrement the counter. If counter==0: res_q<=alu_res, flags_q<={alu_neg,alu_zero,alu_cout,alu_ovf}, res_valid<=1, done<=1 for exactly one cycle, go to LOAD_A.
- EXEC lasts exactly SETTLE cycles; the capture uses ALU outputs sampled at the end of the last EXEC cycle.
- Without a step, every LOAD state holds; alu_* outputs change only on their own load.
- Steps arriving in EXEC are discarded, not queued. A press whose rising edge falls in EXEC does not load A.
- Latency: last step edge to done = SETTLE+1 clock edges (load edge plus SETTLE EXEC edges).

Result/flag hold:
- res_q/flags_q keep the previous result through LOAD_A/LOAD_B/LOAD_OP.
- res_valid drops on the edge that loads a new A.
- alu_a/alu_b/alu_sel/alu_flagin stay stable throughout EXEC and after capture, so the ALU output keeps matching res_q until new loads.
- Widths: all data paths are exactly N bits; no extension or truncation; data_in is sampled unmodified.
- Reset or clr mid-EXEC aborts the operation: no capture, no done, state=LOAD_A.

Test Plan:
- Reset with enter held high, then release/press once -> no step during hold; single step after press loads alu_a; state_o 0->1.
- N=3, SETTLE=1, ALU connected: steps with data_in=3, data_in=5, sel_in=0 -> alu_a=3, alu_b=5, alu_sel=0; done 2 edges after third step; res_q=0, flags_q={0,1,1,1}, res_valid=1.
- SETTLE=3, sel_in=4 (AND), A=6, B=3 -> EXEC for exactly 3 cycles; res_q=2; flags_q=0; done single-cycle pulse.
- Extra enter press during EXEC -> ignored; state returns to LOAD_A; alu_a unchanged until the next genuine step.
- Complete one operation, then step new A=1 -> res_valid drops on that edge; res_q still holds the old value.
- Assert clr in LOAD_OP, and separately drive rst_n low mid-EXEC -> all outputs at reset values; no done pulse; state_o=0.
